rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one grant may be held (legal range 2..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous and active-high; one clock, no other clock domains.
REQ-004 req  input  8  request vector; bit i high = requester i wants the shared resource.
REQ-005 grant  output  8  one-hot grant vector, registered.
REQ-006 gnt_id  output  3  binary index of the granted requester, registered; valid only when gnt_v=1.
REQ-007 gnt_v  output  1  high while any grant is active; equals OR of grant.
REQ-008 timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-009 Two states SHALL exist: IDLE (no grant) and BUSY (one grant held).
REQ-010 A 3-bit priority pointer ptr SHALL name the highest-priority requester; the search order is ptr, ptr+1, ... ptr+7, all mod 8.
REQ-011 In IDLE with req != 0, the first set bit in search order SHALL be granted: grant, gnt_id and gnt_v update on the next rising edge, and the state moves to BUSY.
REQ-012 In IDLE with req == 0, the outputs SHALL stay at 0 and ptr SHALL hold.
REQ-013 In BUSY, only req[gnt_id] SHALL be examined; changes on other req bits SHALL NOT affect grant.
REQ-014 Release: in BUSY with req[gnt_id]=0 sampled, the next edge SHALL clear grant, gnt_v and gnt_id, set ptr = gnt_id+1 mod 8 (7 wraps to 0), and return to IDLE.
REQ-015 Hold counter: the counter SHALL clear on grant and increment on each BUSY cycle, so that grant is high for at most MAX_HOLD consecutive cycles.
REQ-016 Timeout: when the hold counter reaches MAX_HOLD-1 while req[gnt_id]=1, the next edge SHALL clear the grant, set ptr = gnt_id+1 mod 8, return to IDLE, and pulse timeout for exactly that one cycle.
REQ-017 If release and timeout coincide (req[gnt_id] drops on the terminal count cycle), the event SHALL be treated as a release, with no timeout pulse.
REQ-018 At least one IDLE cycle (gnt_v=0) SHALL separate any two grants, including a re-grant to the same requester.
REQ-019 A requester still asserting req after a timeout SHALL be re-eligible, but at lowest priority (ptr has moved past it).
REQ-020 grant SHALL always be one-hot or zero, with gnt_v == |grant and grant == (1 << gnt_id) whenever gnt_v=1.
REQ-021 The design SHALL contain no combinational path from req to any output; all outputs are registered.

Reset
REQ-022 While rst=1, grant, gnt_id, gnt_v, timeout, ptr and the hold counter SHALL be 0 and the state IDLE, taking effect immediately without waiting for clk.
REQ-023 Reset asserted mid-grant SHALL drop grant asynchronously; after rst falls, arbitration SHALL restart from ptr=0 on the first edge with req != 0.
REQ-024 No grant SHALL be issued on the edge coincident with or preceding rst deassertion.

Verification
REQ-025 Single requester: after reset, req=8'b0000_0100 held 3 cycles then 0 -> grant=8'b0000_0100, gnt_id=2 one edge after req, held 3 cycles, cleared, ptr=3.
REQ-026 Rotation: req=8'hFF held constant, MAX_HOLD=4 -> grants go in the order id 0,1,2,...,7,0; each grant lasts 4 cycles with a timeout pulse, followed by 1 idle cycle.
REQ-027 Wrap priority: ptr=7 (after a grant to 6 released), req=8'b1000_0001 -> gnt_id=7 first; after its release -> gnt_id=0.
REQ-028 Coincident release/timeout: MAX_HOLD=4, req[3] dropped on grant cycle 4 -> grant clears, timeout stays 0.
REQ-029 Reset mid-grant: gnt_id=5 active, rst pulsed between edges -> grant=0 immediately; with req=8'b0010_0001 after reset -> gnt_id=0.
REQ-030 Bench SHALL check the REQ-020 invariants every cycle, and end with a PASS/FAIL count summary.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      request vector, bit i = requester i
//   grant    registered one-hot grant
//   gnt_id   registered index of the granted requester
//   gnt_v    high while any grant is held
//   timeout  one-cycle pulse when a grant is cut off at the hold limit
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] gnt_id,
    output logic       gnt_v,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Hold counter value on the last cycle a grant may stay high.
    localparam logic [7:0] TERM = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] id_q, id_d;
    logic       to_q, to_d;

    logic       pick_v;
    logic [2:0] pick_id;
    logic [2:0] idx;

    // Rotating priority search: walk offsets from 7 down to 0 so the
    // requester closest to ptr is the last (and winning) assignment.
    always_comb begin
        pick_v  = 1'b0;
        pick_id = ptr_q;
        idx     = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr_q + 3'(i);
            if (req[idx]) begin
                pick_v  = 1'b1;
                pick_id = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        id_d    = id_q;
        to_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_v) begin
                    state_d = BUSY;
                    id_d    = pick_id;
                    grant_d = 8'd1 << pick_id;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // A release wins over a coincident terminal count.
                if (!req[id_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    ptr_d   = id_q + 3'd1;
                    cnt_d   = '0;
                end else if (cnt_q == TERM) begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
                    ptr_d   = id_q + 3'd1;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            to_q    <= to_d;
        end
    end

    assign grant   = grant_q;
    assign gnt_id  = id_q;
    assign gnt_v   = |grant_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8 (MAX_HOLD = 4).
// Ports: none; drives clk/rst/req and checks grant outputs.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] gnt_id;
    logic       gnt_v;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .gnt_v   (gnt_v),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Structural invariants, sampled away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (((grant & (grant - 8'd1)) != 8'd0) ||
            (gnt_v !== (|grant)) ||
            (gnt_v && (grant !== (8'd1 << gnt_id)))) begin
            errors++;
            $display("FAIL invariant: grant=%b gnt_id=%0d gnt_v=%b",
                     grant, gnt_id, gnt_v);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 8'h00;
        #2;
        checks++;
        if ({grant, gnt_id, gnt_v, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_async: got %b/%0d/%b/%b want 0",
                     grant, gnt_id, gnt_v, timeout);
        end
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({grant, gnt_id, gnt_v, timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_release: got %b/%0d/%b/%b want 0",
                     grant, gnt_id, gnt_v, timeout);
        end
    endtask

    task automatic test_single;
        req = 8'b0000_0100;
        tick();
        checks++;
        if (grant !== 8'b0000_0100 || gnt_id !== 3'd2 || gnt_v !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got %b id %0d want 00000100 id 2",
                     grant, gnt_id);
        end
        // Other requesters appear while busy; grant must not move.
        req = 8'hF4;
        tick();
        checks++;
        if (grant !== 8'b0000_0100) begin
            errors++;
            $display("FAIL busy_ignore: got %b want 00000100", grant);
        end
        req = 8'b0000_0100;
        tick();
        checks++;
        if (grant !== 8'b0000_0100) begin
            errors++;
            $display("FAIL single_hold3: got %b want 00000100", grant);
        end
        req = 8'h00;
        tick();
        checks++;
        if (grant !== 8'h00 || gnt_v !== 1'b0 || gnt_id !== 3'd0 ||
            timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got %b/%0d/%b/%b want 0",
                     grant, gnt_id, gnt_v, timeout);
        end
        // ptr is now 3: requester 3 beats requester 0.
        req = 8'b0000_1001;
        tick();
        checks++;
        if (gnt_id !== 3'd3 || grant !== 8'b0000_1000) begin
            errors++;
            $display("FAIL ptr_after_release: got id %0d want 3", gnt_id);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt_v !== 1'b0) begin
            errors++;
            $display("FAIL release_3: got gnt_v %b want 0", gnt_v);
        end
    endtask

    task automatic test_wrap;
        req = 8'b0100_0000;
        tick();
        checks++;
        if (gnt_id !== 3'd6) begin
            errors++;
            $display("FAIL wrap_grant6: got id %0d want 6", gnt_id);
        end
        req = 8'h00;
        tick();
        req = 8'b1000_0001;
        tick();
        checks++;
        if (gnt_id !== 3'd7 || grant !== 8'b1000_0000) begin
            errors++;
            $display("FAIL wrap_grant7: got id %0d want 7", gnt_id);
        end
        req = 8'b0000_0001;
        tick();
        checks++;
        if (gnt_v !== 1'b0) begin
            errors++;
            $display("FAIL wrap_idle_gap: got gnt_v %b want 0", gnt_v);
        end
        tick();
        checks++;
        if (gnt_id !== 3'd0 || grant !== 8'b0000_0001) begin
            errors++;
            $display("FAIL wrap_grant0: got id %0d grant %b want 0 00000001",
                     gnt_id, grant);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_coincident;
        req = 8'b0000_1000;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (gnt_id !== 3'd3 || gnt_v !== 1'b1) begin
            errors++;
            $display("FAIL coin_cycle4: got id %0d v %b want 3 1",
                     gnt_id, gnt_v);
        end
        req = 8'h00;
        tick();
        checks++;
        if (gnt_v !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL coin_release: got v %b timeout %b want 0 0",
                     gnt_v, timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL coin_no_pulse: got timeout %b want 0", timeout);
        end
    endtask

    task automatic test_rotation;
        logic [2:0] exp_id;
        rst = 1'b1;
        req = 8'hFF;
        tick();
        checks++;
        if (gnt_v !== 1'b0) begin
            errors++;
            $display("FAIL rot_in_reset: got gnt_v %b want 0", gnt_v);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_id = 3'(k % 8);
            tick();
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (gnt_v !== 1'b1 || gnt_id !== exp_id || timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL rot_hold k=%0d c=%0d: got v %b id %0d to %b want 1 %0d 0",
                             k, c, gnt_v, gnt_id, timeout, exp_id);
                end
                if (c < 3) tick();
            end
            tick();
            checks++;
            if (gnt_v !== 1'b0 || timeout !== 1'b1) begin
                errors++;
                $display("FAIL rot_timeout k=%0d: got v %b to %b want 0 1",
                         k, gnt_v, timeout);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'b0010_0000;
        tick();
        checks++;
        if (gnt_id !== 3'd5 || gnt_v !== 1'b1) begin
            errors++;
            $display("FAIL mid_grant5: got id %0d v %b want 5 1", gnt_id, gnt_v);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 8'h00 || gnt_v !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_async_drop: got %b/%0d/%b want 0",
                     grant, gnt_id, gnt_v);
        end
        #1;
        rst = 1'b0;
        req = 8'b0010_0001;
        tick();
        checks++;
        if (gnt_id !== 3'd0 || grant !== 8'b0000_0001) begin
            errors++;
            $display("FAIL mid_restart: got id %0d grant %b want 0 00000001",
                     gnt_id, grant);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        test_reset();
        test_single();
        test_wrap();
        test_coincident();
        test_rotation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
